// File: rtl/car_pkg.sv
// Shared types and timing defaults for the indicator/hazard controller.
// Timing defaults assume a 50 MHz core clock.
package car_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEFT,
    RIGHT,
    LANE_L,
    LANE_R
  } state_t;

  localparam int CLK_HZ              = 50_000_000;
  localparam int BLINK_HALF_DEF      = 16_666_667;
  localparam int DEBOUNCE_CYCLES_DEF = 500_000;
  localparam int LANE_TAP_DEF        = 25_000_000;
  localparam int LANE_BLINKS_DEF     = 3;

  // Counter width able to hold 0..limit-1, never narrower than one bit.
  function automatic int cnt_w(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/debounce.sv
// Level debouncer: dout follows din after CYCLES consecutive disagreeing samples.
// Latency CYCLES clocks from a stable change; any glitch restarts the count.
module debounce
  import car_pkg::*;
#(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int W = cnt_w(CYCLES);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      dout <= din;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/turn_signal_ctrl.sv
// Turn-signal / hazard controller: debounced stalks and hazard button drive the
// indicator FSM and blink phase; lamps assert 2 edges after a debounced change.
module turn_signal_ctrl
  import car_pkg::*;
#(
  parameter int BLINK_HALF      = BLINK_HALF_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LANE_TAP        = LANE_TAP_DEF,
  parameter int LANE_BLINKS     = LANE_BLINKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_left,
  input  logic sw_right,
  input  logic btn_hazard,
  output logic lamp_left,
  output logic lamp_right,
  output logic turn_signal_on,
  output logic hazard_on
);

  localparam int PW = cnt_w(BLINK_HALF);
  localparam int HW = cnt_w(LANE_TAP + 1);
  localparam int BW = cnt_w(LANE_BLINKS + 1);
  localparam logic [PW-1:0] P_LAST    = PW'(BLINK_HALF - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LANE_TAP);
  localparam logic [BW-1:0] BLINK_END = BW'(LANE_BLINKS);

  logic l, r, hz_db, hz_prev, hz_pulse;
  state_t state, state_nxt;
  logic phase, phase_nxt, hazard_en, hazard_nxt, restart;
  logic [PW-1:0] pcnt, pcnt_nxt, gen_pcnt;
  logic gen_phase, gen_fall;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [BW-1:0] blink_cnt, blink_nxt, blink_inc;

  debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_l  (.clk(clk), .rst(rst), .din(sw_left),    .dout(l));
  debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_r  (.clk(clk), .rst(rst), .din(sw_right),   .dout(r));
  debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_hz (.clk(clk), .rst(rst), .din(btn_hazard), .dout(hz_db));

  assign hz_pulse  = hz_db & ~hz_prev;
  assign blink_inc = blink_cnt + 1'b1;

  // Free-running blink generator; overridden below on restart or deactivation.
  always_comb begin
    gen_phase = phase;
    gen_pcnt  = pcnt + 1'b1;
    if (pcnt == P_LAST) begin
      gen_pcnt  = '0;
      gen_phase = ~phase;
    end
    gen_fall = phase & ~gen_phase;
  end

  always_comb begin
    state_nxt  = state;
    hazard_nxt = hazard_en ^ hz_pulse;
    phase_nxt  = gen_phase;
    pcnt_nxt   = gen_pcnt;
    hold_nxt   = hold_cnt;
    blink_nxt  = blink_cnt;
    restart    = 1'b0;

    if (hz_pulse) begin
      state_nxt = IDLE;
      restart   = ~hazard_en;
    end else if (!hazard_en) begin
      case (state)
        IDLE: begin
          if (l && !r) begin
            state_nxt = LEFT;
            restart   = 1'b1;
            hold_nxt  = '0;
          end else if (r && !l) begin
            state_nxt = RIGHT;
            restart   = 1'b1;
            hold_nxt  = '0;
          end
        end
        LEFT: begin
          if (r && !l) begin
            state_nxt = RIGHT;
            restart   = 1'b1;
            hold_nxt  = '0;
          end else if (!l) begin
            state_nxt = (hold_cnt < HOLD_MAX) ? LANE_L : IDLE;
            blink_nxt = '0;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end
        RIGHT: begin
          if (l && !r) begin
            state_nxt = LEFT;
            restart   = 1'b1;
            hold_nxt  = '0;
          end else if (!r) begin
            state_nxt = (hold_cnt < HOLD_MAX) ? LANE_R : IDLE;
            blink_nxt = '0;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end
        LANE_L: begin
          if (l) begin
            state_nxt = LEFT;
            hold_nxt  = '0;
          end else if (r) begin
            state_nxt = RIGHT;
            restart   = 1'b1;
            hold_nxt  = '0;
          end else if (gen_fall) begin
            blink_nxt = blink_inc;
            if (blink_inc == BLINK_END) state_nxt = IDLE;
          end
        end
        LANE_R: begin
          if (r) begin
            state_nxt = RIGHT;
            hold_nxt  = '0;
          end else if (l) begin
            state_nxt = LEFT;
            restart   = 1'b1;
            hold_nxt  = '0;
          end else if (gen_fall) begin
            blink_nxt = blink_inc;
            if (blink_inc == BLINK_END) state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Restart wins; otherwise an idle, non-hazard controller parks phase at 0.
    if (restart) begin
      phase_nxt = 1'b1;
      pcnt_nxt  = '0;
    end else if (!hazard_nxt && state_nxt == IDLE) begin
      phase_nxt = 1'b0;
      pcnt_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      hazard_en      <= 1'b0;
      hz_prev        <= 1'b0;
      phase          <= 1'b0;
      pcnt           <= '0;
      hold_cnt       <= '0;
      blink_cnt      <= '0;
      lamp_left      <= 1'b0;
      lamp_right     <= 1'b0;
      turn_signal_on <= 1'b0;
    end else begin
      state          <= state_nxt;
      hazard_en      <= hazard_nxt;
      hz_prev        <= hz_db;
      phase          <= phase_nxt;
      pcnt           <= pcnt_nxt;
      hold_cnt       <= hold_nxt;
      blink_cnt      <= blink_nxt;
      lamp_left      <= phase & (hazard_en | state == LEFT  | state == LANE_L);
      lamp_right     <= phase & (hazard_en | state == RIGHT | state == LANE_R);
      turn_signal_on <= phase & (hazard_en | state != IDLE);
    end
  end

  assign hazard_on = hazard_en;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Directed scenarios plus randomized stalk/hazard activity, every cycle compared
// against a behavioural model built from blink-time arithmetic and input history.
module tb_turn_signal_ctrl;

  localparam int BH  = 10;
  localparam int DB  = 4;
  localparam int TAP = 20;
  localparam int LB  = 3;

  localparam int M_IDLE = 0, M_L = 1, M_R = 2, M_LL = 3, M_LR = 4;

  logic clk = 1'b0;
  logic rst, sw_left, sw_right, btn_hazard;
  logic lamp_left, lamp_right, turn_signal_on, hazard_on;

  int checks = 0;
  int errors = 0;

  turn_signal_ctrl #(
    .BLINK_HALF(BH), .DEBOUNCE_CYCLES(DB), .LANE_TAP(TAP), .LANE_BLINKS(LB)
  ) dut (
    .clk(clk), .rst(rst), .sw_left(sw_left), .sw_right(sw_right), .btn_hazard(btn_hazard),
    .lamp_left(lamp_left), .lamp_right(lamp_right), .turn_signal_on(turn_signal_on),
    .hazard_on(hazard_on)
  );

  always #5 clk = ~clk;

  // Model state: debounced levels derive from the last DB raw samples; blink
  // phase derives from the number of active cycles since the last restart.
  int m_db [3];
  int hist [3][DB];
  int m_prev_h, m_haz, m_mode, m_t, m_enter, m_falls, cyc;
  int e_ll, e_lr, e_ts, e_hz;

  function automatic int ph(input int t);
    return ((t / BH) % 2 == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_db[k] = 0;
      for (int j = 0; j < DB; j++) hist[k][j] = 0;
    end
    m_prev_h = 0; m_haz = 0; m_mode = M_IDLE; m_t = 0; m_enter = 0; m_falls = 0; cyc = 0;
    e_ll = 0; e_lr = 0; e_ts = 0; e_hz = 0;
  endtask

  task automatic model_edge(input int raw_l, input int raw_r, input int raw_h);
    int l, r, h, pn, own, oth, held, all_diff;
    int raw [3];
    l = m_db[0]; r = m_db[1]; h = m_db[2];
    pn = (m_haz != 0 || m_mode != M_IDLE) ? ph(m_t) : 0;
    e_ll = pn & ((m_haz != 0 || m_mode == M_L || m_mode == M_LL) ? 1 : 0);
    e_lr = pn & ((m_haz != 0 || m_mode == M_R || m_mode == M_LR) ? 1 : 0);
    e_ts = pn;
    if (h != 0 && m_prev_h == 0) begin
      m_haz = (m_haz != 0) ? 0 : 1;
      m_mode = M_IDLE;
      m_t = 0;
    end else if (m_haz != 0) begin
      m_t++;
    end else begin
      own = (m_mode == M_L || m_mode == M_LL) ? l : r;
      oth = (m_mode == M_L || m_mode == M_LL) ? r : l;
      case (m_mode)
        M_IDLE: begin
          if (l != 0 && r == 0) begin m_mode = M_L; m_t = 0; m_enter = cyc; end
          else if (r != 0 && l == 0) begin m_mode = M_R; m_t = 0; m_enter = cyc; end
        end
        M_L, M_R: begin
          held = cyc - m_enter - 1;
          if (held > TAP) held = TAP;
          if (oth != 0 && own == 0) begin
            m_mode = (m_mode == M_L) ? M_R : M_L; m_t = 0; m_enter = cyc;
          end else if (own == 0) begin
            if (held < TAP) begin
              m_mode = (m_mode == M_L) ? M_LL : M_LR; m_falls = 0; m_t++;
            end else m_mode = M_IDLE;
          end else m_t++;
        end
        default: begin
          if (own != 0) begin
            m_mode = (m_mode == M_LL) ? M_L : M_R; m_enter = cyc; m_t++;
          end else if (oth != 0) begin
            m_mode = (m_mode == M_LL) ? M_R : M_L; m_t = 0; m_enter = cyc;
          end else begin
            if (ph(m_t) == 1 && ph(m_t + 1) == 0) m_falls++;
            if (m_falls == LB) m_mode = M_IDLE;
            else m_t++;
          end
        end
      endcase
    end
    e_hz = m_haz;
    m_prev_h = h;
    raw[0] = raw_l; raw[1] = raw_r; raw[2] = raw_h;
    for (int k = 0; k < 3; k++) begin
      for (int j = DB - 1; j > 0; j--) hist[k][j] = hist[k][j-1];
      hist[k][0] = raw[k];
      all_diff = 1;
      for (int j = 0; j < DB; j++) if (hist[k][j] == m_db[k]) all_diff = 0;
      if (all_diff != 0) m_db[k] = raw[k];
    end
    cyc++;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(int'(sw_left), int'(sw_right), int'(btn_hazard));
    @(negedge clk);
    check("lamp_left", int'(lamp_left), e_ll);
    check("lamp_right", int'(lamp_right), e_lr);
    check("turn_signal_on", int'(turn_signal_on), e_ts);
    check("hazard_on", int'(hazard_on), e_hz);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int first, highs, edges, pulses, wmin, wmax, w, prev_ts, prev_lr, busy;
    rst = 1'b0; sw_left = 1'b1; sw_right = 1'b0; btn_hazard = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_lamp_left", int'(lamp_left), 0);
    check("reset_lamp_right", int'(lamp_right), 0);
    check("reset_ts", int'(turn_signal_on), 0);
    check("reset_hazard", int'(hazard_on), 0);

    // Reset release with the left stalk already held.
    rst = 1'b1;
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (lamp_left && first == 0) first = i;
    end
    check("first_lamp_edge", first, DB + 2);
    ticks(40);

    // Long hold released: no lane-change blinks afterwards.
    sw_left = 1'b0;
    ticks(DB + 2);
    check("long_hold_off", int'(lamp_left), 0);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      highs += int'(lamp_left) + int'(lamp_right);
    end
    check("long_hold_no_blink", highs, 0);

    // Lane-change tap on the right stalk.
    edges = 0; pulses = 0; wmin = 1000; wmax = 0; w = 0;
    prev_ts = int'(turn_signal_on); prev_lr = int'(lamp_right);
    sw_right = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (i == 8) sw_right = 1'b0;
      tick();
      if (int'(turn_signal_on) != prev_ts) edges++;
      if (lamp_right) w++;
      if (lamp_right && prev_lr == 0) pulses++;
      if (!lamp_right && prev_lr == 1) begin
        if (w < wmin) wmin = w;
        if (w > wmax) wmax = w;
        w = 0;
      end
      prev_ts = int'(turn_signal_on); prev_lr = int'(lamp_right);
    end
    check("tap_ts_edges", edges, 2 * LB);
    check("tap_pulses", pulses, LB);
    check("tap_width_min", wmin, BH);
    check("tap_width_max", wmax, BH);

    // Hazard pressed over an active left indication, then released.
    sw_left = 1'b1;
    ticks(20);
    btn_hazard = 1'b1; ticks(6); btn_hazard = 1'b0;
    ticks(30);
    check("hazard_engaged", int'(hazard_on), 1);
    btn_hazard = 1'b1; ticks(6); btn_hazard = 1'b0;
    ticks(30);
    check("hazard_released", int'(hazard_on), 0);
    sw_left = 1'b0;
    ticks(60);

    // Short glitches must be ignored.
    sw_left = 1'b1; ticks(DB - 1); sw_left = 1'b0;
    btn_hazard = 1'b1; ticks(DB - 1); btn_hazard = 1'b0;
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      busy += int'(lamp_left) + int'(lamp_right) + int'(turn_signal_on) + int'(hazard_on);
    end
    check("glitch_quiet", busy, 0);

    // Left to right switch in the middle of an ON phase.
    sw_left = 1'b1;
    first = 0;
    for (int i = 0; i < 20 && first == 0; i++) begin
      tick();
      if (lamp_left) first = 1;
    end
    check("switch_left_on", first, 1);
    ticks(4);
    sw_left = 1'b0; sw_right = 1'b1;
    w = 0; first = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (lamp_right && first == 0) first = 1;
      if (lamp_right && first == 1) w++;
      if (!lamp_right && first == 1 && w > 0) first = 2;
    end
    check("switch_right_width", w, BH);
    sw_right = 1'b0;
    ticks(60);

    // Randomized stalk / hazard activity.
    for (int s = 0; s < 70; s++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      sw_left    = (sel < 4) || (sel == 8);
      sw_right   = (sel >= 4 && sel < 7) || (sel == 8);
      btn_hazard = ($urandom_range(0, 7) == 0);
      ticks(int'($urandom_range(1, 35)));
    end
    sw_left = 1'b0; sw_right = 1'b0; btn_hazard = 1'b0;
    ticks(80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
